idli_ctl_m: RTL

- Core sequencing and memory-ownership controller.
- Owns the free-running 2-bit slice counter, which was previously held inline in the top level.
- Arbitrates the single SQI memory datapath between three requesters: instruction fetch (F), data read (R) and data write (W).
- Drives the SQI mux select, the transaction-start strobe and the execute stall. All ownership changes are aligned to 16-bit word boundaries (4 slices).

---
 rtl/idli_ctl_m.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/idli_ctl_m.sv
// ---------------------------------------------------------------------------
// idli_ctl_m -- core sequencing and SQI memory-ownership controller.
//
// Owns the free-running 2-bit slice counter and arbitrates the single SQI
// datapath between instruction fetch (F), data read (R) and data write (W).
// Every ownership change lands on a word boundary: decisions are taken in the
// ctr==3 cycle and become visible on the following ctr==0 cycle.  Between
// two owners there is always one full TURN word (no grant, sel=0), which
// gives SQI time for CS deassert and bus turnaround.
//
// Parameters:
//   MAX_HOLD  max consecutive words one owner keeps the bus while another
//             requester waits; 0 disables preemption.
//
// Ports:
//   i_ctl_gck        core clock
//   i_ctl_rst        synchronous active-high reset
//   o_ctl_ctr        slice counter, slice 0 = first slice of a word
//   i_ctl_x_req      level request from F / R / W
//   o_ctl_x_gnt      x currently owns memory
//   i_ctl_redirect   branch redirect pulse, aborts fetch ownership
//   o_ctl_sel        SQI owner select: 0 none, 1 F, 2 R, 3 W
//   o_ctl_start      pulse on slice 0 of the first word of a new ownership
//   o_ctl_preempt    pulse on slice 0 after a forced (MAX_HOLD) release
//   o_ctl_stall      execute stall: a data request is waiting for the bus
//   o_ctl_stall_cnt  saturating stall-cycle counter (IDLI_CTL_PERF_EN only)
//
// Build option:
//   IDLI_CTL_PERF_EN  adds o_ctl_stall_cnt and its counter.
// ---------------------------------------------------------------------------
module idli_ctl_m #(
    parameter int MAX_HOLD = 8
) (
    input  logic        i_ctl_gck,
    input  logic        i_ctl_rst,
    output logic [1:0]  o_ctl_ctr,
    input  logic        i_ctl_f_req,
    output logic        o_ctl_f_gnt,
    input  logic        i_ctl_r_req,
    output logic        o_ctl_r_gnt,
    input  logic        i_ctl_w_req,
    output logic        o_ctl_w_gnt,
    input  logic        i_ctl_redirect,
    output logic [1:0]  o_ctl_sel,
    output logic        o_ctl_start,
    output logic        o_ctl_preempt,
`ifdef IDLI_CTL_PERF_EN
    output logic [15:0] o_ctl_stall_cnt,
`endif
    output logic        o_ctl_stall
);

    typedef logic [1:0] ctr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OWN_F = 3'd1,
        ST_OWN_R = 3'd2,
        ST_OWN_W = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    // Hold counter must be able to represent MAX_HOLD itself.
    localparam int            HW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    // Requester vectors are indexed bit0=F, bit1=R, bit2=W.
    localparam logic [2:0] B_F = 3'b001;
    localparam logic [2:0] B_R = 3'b010;
    localparam logic [2:0] B_W = 3'b100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctr_t          ctr_q,     ctr_d;
    state_t        state_q,   state_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic          redir_q,   redir_d;
    logic [2:0]    mask_q,    mask_d;
    logic          f_gnt_q,   f_gnt_d;
    logic          r_gnt_q,   r_gnt_d;
    logic          w_gnt_q,   w_gnt_d;
    logic [1:0]    sel_q,     sel_d;
    logic          start_q,   start_d;
    logic          preempt_q, preempt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0] req;
    logic [2:0] elig;
    logic [2:0] own_bit;
    logic       owner_req;
    logic       others_req;
    logic       redir_eff;
    logic       hold_full;

    assign req = {i_ctl_w_req, i_ctl_r_req, i_ctl_f_req};

    // A redirect arriving in the ctr==3 cycle itself must still count for
    // that evaluation, so the live pulse is merged with the latch.
    assign redir_eff = redir_q | i_ctl_redirect;

    assign hold_full = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

    always_comb begin
        own_bit = 3'b000;
        case (state_q)
            ST_OWN_F: own_bit = B_F;
            ST_OWN_R: own_bit = B_R;
            ST_OWN_W: own_bit = B_W;
            default:  own_bit = 3'b000;
        endcase
    end

    assign owner_req  = |(req & own_bit);
    assign others_req = |(req & ~own_bit);

    // A requester that was just preempted sits out one arbitration, unless
    // nobody else wants the bus (then masking it would only waste words).
    always_comb begin
        elig = req & ~mask_q;
        if (elig == 3'b000) begin
            elig = req;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ctr_d     = ctr_q + 2'd1;
        state_d   = state_q;
        hold_d    = hold_q;
        mask_d    = mask_q;
        redir_d   = redir_eff;
        start_d   = 1'b0;
        preempt_d = 1'b0;

        if (ctr_q == 2'd3) begin
            // The latch is consumed by this evaluation whatever the state.
            redir_d = 1'b0;
            case (state_q)
                ST_IDLE, ST_TURN: begin
                    mask_d = 3'b000;
                    if (elig[2]) begin
                        state_d = ST_OWN_W;
                    end else if (elig[1]) begin
                        state_d = ST_OWN_R;
                    end else if (elig[0]) begin
                        state_d = ST_OWN_F;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if (elig != 3'b000) begin
                        start_d = 1'b1;
                        hold_d  = HOLD_ONE;
                    end
                end
                default: begin
                    // Ordering matters: request-low and redirect releases
                    // win over preemption and suppress its pulse and mask.
                    if (!owner_req) begin
                        state_d = ST_TURN;
                    end else if ((state_q == ST_OWN_F) && redir_eff) begin
                        state_d = ST_TURN;
                    end else if (hold_full && others_req) begin
                        state_d   = ST_TURN;
                        preempt_d = 1'b1;
                        mask_d    = mask_q | own_bit;
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
            endcase
        end
    end

    // Grant outputs are registered images of the next state.
    always_comb begin
        f_gnt_d = (state_d == ST_OWN_F);
        r_gnt_d = (state_d == ST_OWN_R);
        w_gnt_d = (state_d == ST_OWN_W);
        case (state_d)
            ST_OWN_F: sel_d = 2'd1;
            ST_OWN_R: sel_d = 2'd2;
            ST_OWN_W: sel_d = 2'd3;
            default:  sel_d = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge i_ctl_gck) begin
        if (i_ctl_rst) begin
            ctr_q     <= '0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            redir_q   <= 1'b0;
            mask_q    <= 3'b000;
            f_gnt_q   <= 1'b0;
            r_gnt_q   <= 1'b0;
            w_gnt_q   <= 1'b0;
            sel_q     <= 2'd0;
            start_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            redir_q   <= redir_d;
            mask_q    <= mask_d;
            f_gnt_q   <= f_gnt_d;
            r_gnt_q   <= r_gnt_d;
            w_gnt_q   <= w_gnt_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            preempt_q <= preempt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ctl_ctr     = ctr_q;
    assign o_ctl_f_gnt   = f_gnt_q;
    assign o_ctl_r_gnt   = r_gnt_q;
    assign o_ctl_w_gnt   = w_gnt_q;
    assign o_ctl_sel     = sel_q;
    assign o_ctl_start   = start_q;
    assign o_ctl_preempt = preempt_q;

    // Fetch waiting is hidden by the prefetch path, so only data stalls.
    assign o_ctl_stall = (i_ctl_r_req & ~r_gnt_q) | (i_ctl_w_req & ~w_gnt_q);

`ifdef IDLI_CTL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_ctl_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_ctl_gck) begin
        if (i_ctl_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_ctl_stall_cnt = stall_cnt_q;
`endif

endmodule
